// File: rtl/reg_dump_reader.sv
// Walks every register address, samples the register file read port and streams {addr, data}
// beats over valid/ready. Optional trailing checksum beat when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_reader #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    output logic         Busy,
    output logic         Done,
    output logic [D-1:0] RdAddr,
    input  logic [W-1:0] RdData,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [D-1:0] OutAddr,
    output logic [W-1:0] OutData,
    output logic         OutLast
);

    localparam logic [D-1:0] LastAddr = {D{1'b1}};

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StSend,
        StDone
`ifdef REG_DUMP_CHECKSUM_EN
        , StSum
`endif
    } state_e;

    state_e       state_q, state_d;
    logic [D-1:0] cnt_q, cnt_d;
    logic [D-1:0] out_addr_q, out_addr_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         accept;
    logic         at_last;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [W-1:0] sum_q, sum_d;
`endif

    assign accept  = OutValid & OutReady;
    assign at_last = (cnt_q == LastAddr);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StRead;
                end
            end
            StRead: state_d = StSend;
            StSend: begin
                if (accept) begin
                    if (!at_last) begin
                        state_d = StRead;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_d = StSum;
`else
                        state_d = StDone;
`endif
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            StSum: begin
                if (accept) begin
                    state_d = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        Busy     = 1'b1;
        Done     = 1'b0;
        OutValid = 1'b0;
        OutLast  = 1'b0;
        unique case (state_q)
            StIdle: Busy = 1'b0;
            StRead: ;
            StSend: begin
                OutValid = 1'b1;
`ifndef REG_DUMP_CHECKSUM_EN
                OutLast  = (out_addr_q == LastAddr);
`endif
            end
`ifdef REG_DUMP_CHECKSUM_EN
            StSum: begin
                OutValid = 1'b1;
                OutLast  = 1'b1;
            end
`endif
            StDone:  Done = 1'b1;
            default: Busy = 1'b0;
        endcase
    end

    // Datapath next-state: address counter, captured beat, optional running sum
    always_comb begin
        cnt_d      = cnt_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
`ifdef REG_DUMP_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    cnt_d = '0;
`ifdef REG_DUMP_CHECKSUM_EN
                    sum_d = '0;
`endif
                end
            end
            StRead: begin
                out_addr_d = cnt_q;
                out_data_d = RdData;
            end
            StSend: begin
                if (accept) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    sum_d = sum_q + out_data_q;
                    // Checksum beat reuses the final address; data becomes the full sum
                    if (at_last) begin
                        out_data_d = sum_q + out_data_q;
                    end
`endif
                    if (!at_last) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            StSum: ;
`endif
            // Park the read address at 0 between dumps
            StDone:  cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
`ifdef REG_DUMP_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign RdAddr  = cnt_q;
    assign OutAddr = out_addr_q;
    assign OutData = out_data_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a behavioural register file on the read port.
// Honours REG_DUMP_CHECKSUM_EN to expect the trailing checksum beat.
module tb_reg_dump_reader;

    localparam int W = 8;
    localparam int D = 4;
    localparam int N = 16;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int NB = N + 1;
    localparam int DoneLat = 34;
`else
    localparam int NB = N;
    localparam int DoneLat = 33;
`endif

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic         Busy;
    logic         Done;
    logic [D-1:0] RdAddr;
    logic [W-1:0] RdData;
    logic         OutValid;
    logic         OutReady;
    logic [D-1:0] OutAddr;
    logic [W-1:0] OutData;
    logic         OutLast;

    logic [W-1:0] regs    [N];
    logic [W-1:0] exp_reg [N];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int nbeats = 0;
    int beat_addr [256];
    int beat_data [256];
    int beat_last [256];
    int done_cnt = 0;
    int done_cyc = 0;

    reg_dump_reader #(.W(W), .D(D)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Busy     (Busy),
        .Done     (Done),
        .RdAddr   (RdAddr),
        .RdData   (RdData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutAddr  (OutAddr),
        .OutData  (OutData),
        .OutLast  (OutLast)
    );

    always #5 Clk = ~Clk;

    assign RdData = regs[RdAddr];

    always @(posedge Clk) cyc <= cyc + 1;

    // Record accepted beats and Done pulses mid-cycle
    always @(negedge Clk) begin
        if (!Reset) begin
            if (OutValid && OutReady && nbeats < 256) begin
                beat_addr[nbeats] = int'(OutAddr);
                beat_data[nbeats] = int'(OutData);
                beat_last[nbeats] = int'(OutLast);
                nbeats++;
            end
            if (Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_dump(output int sc);
        Start = 1'b1;
        sc = cyc;
        step();
        Start = 1'b0;
    endtask

    task automatic wait_beat(input int addr);
        int found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            if (OutValid && int'(OutAddr) == addr) found = 1;
            else step();
        end
        chk($sformatf("wait beat %0d", addr), found, 1);
    endtask

    task automatic wait_done(input int dn0);
        for (int k = 0; k < 200 && done_cnt == dn0; k++) step();
        step();
    endtask

    task automatic check_dump(input string t, input int sc, input int extra, input int nb0,
                              input int dn0);
        int exp_last;
        int sum;
        sum = 0;
        chk($sformatf("%s beat count", t), nbeats - nb0, NB);
        for (int i = 0; i < N; i++) begin
            sum = (sum + int'(exp_reg[i])) % 256;
`ifdef REG_DUMP_CHECKSUM_EN
            exp_last = 0;
`else
            exp_last = (i == N - 1) ? 1 : 0;
`endif
            chk($sformatf("%s beat%0d addr", t, i), beat_addr[nb0 + i], i);
            chk($sformatf("%s beat%0d data", t, i), beat_data[nb0 + i], int'(exp_reg[i]));
            chk($sformatf("%s beat%0d last", t, i), beat_last[nb0 + i], exp_last);
        end
`ifdef REG_DUMP_CHECKSUM_EN
        chk($sformatf("%s sum addr", t), beat_addr[nb0 + N], N - 1);
        chk($sformatf("%s sum data", t), beat_data[nb0 + N], sum);
        chk($sformatf("%s sum last", t), beat_last[nb0 + N], 1);
`endif
        chk($sformatf("%s done count", t), done_cnt - dn0, 1);
        chk($sformatf("%s done cycle", t), done_cyc - sc, DoneLat + extra);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int nb0;
        int dn0;

        Reset = 1'b1;
        Start = 1'b0;
        OutReady = 1'b1;
        for (int i = 0; i < N; i++) begin
            regs[i]    = W'(i * 3 + 1);
            exp_reg[i] = W'(i * 3 + 1);
        end
        step();
        step();
        chk("rst busy", int'(Busy), 0);
        chk("rst done", int'(Done), 0);
        chk("rst valid", int'(OutValid), 0);
        chk("rst last", int'(OutLast), 0);
        chk("rst rdaddr", int'(RdAddr), 0);
        chk("rst outaddr", int'(OutAddr), 0);
        chk("rst outdata", int'(OutData), 0);
        Reset = 1'b0;
        step();
        chk("idle busy", int'(Busy), 0);

        // Test 1: plain dump with OutReady held high
        nb0 = nbeats; dn0 = done_cnt;
        start_dump(sc);
        chk("t1 read no valid", int'(OutValid), 0);
        chk("t1 read busy", int'(Busy), 1);
        step();
        chk("t1 first valid", int'(OutValid), 1);
        chk("t1 first addr", int'(OutAddr), 0);
        chk("t1 first data", int'(OutData), 1);
        wait_done(dn0);
        check_dump("t1", sc, 0, nb0, dn0);
        chk("t1 idle after", int'(Busy), 0);

        // Test 2: 5-cycle stall on beat 7
        nb0 = nbeats; dn0 = done_cnt;
        start_dump(sc);
        wait_beat(7);
        OutReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2 stall%0d valid", k), int'(OutValid), 1);
            chk($sformatf("t2 stall%0d addr", k), int'(OutAddr), 7);
            chk($sformatf("t2 stall%0d data", k), int'(OutData), 22);
            step();
        end
        OutReady = 1'b1;
        wait_done(dn0);
        check_dump("t2", sc, 5, nb0, dn0);

        // Test 3: Start while busy is ignored
        nb0 = nbeats; dn0 = done_cnt;
        start_dump(sc);
        wait_beat(4);
        Start = 1'b1;
        step();
        Start = 1'b0;
        wait_done(dn0);
        check_dump("t3", sc, 0, nb0, dn0);
        for (int k = 0; k < 5; k++) step();
        chk("t3 stays idle", int'(Busy), 0);
        chk("t3 no extra beats", nbeats - nb0, NB);

        // Test 4: writes after beat 2's READ but before beat 9's
        nb0 = nbeats; dn0 = done_cnt;
        start_dump(sc);
        wait_beat(3);
        regs[9] = 8'hA5;
        regs[2] = 8'h5A;
        exp_reg[9] = 8'hA5;
        wait_done(dn0);
        check_dump("t4", sc, 0, nb0, dn0);
        regs[9] = W'(9 * 3 + 1);
        regs[2] = W'(2 * 3 + 1);
        exp_reg[9] = W'(9 * 3 + 1);

        // Test 5: reset during SEND of beat 6
        dn0 = done_cnt;
        start_dump(sc);
        wait_beat(6);
        Reset = 1'b1;
        step();
        chk("t5 valid", int'(OutValid), 0);
        chk("t5 busy", int'(Busy), 0);
        chk("t5 rdaddr", int'(RdAddr), 0);
        chk("t5 outaddr", int'(OutAddr), 0);
        chk("t5 outdata", int'(OutData), 0);
        chk("t5 done", int'(Done), 0);
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("t5 no done pulse", done_cnt - dn0, 0);
        chk("t5 idle", int'(Busy), 0);
        nb0 = nbeats; dn0 = done_cnt;
        start_dump(sc);
        wait_done(dn0);
        check_dump("t5", sc, 0, nb0, dn0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
